// File: rtl/keypad_scanner.sv
// Column-scanning controller for a 4x4 active-low matrix keypad, wrapped around an external debouncer.
// Optional two-digit key history is built when KEYPAD_HISTORY_EN is defined.
module keypad_scanner #(
  parameter logic [15:0] SCAN_DIVIDER = 16'd5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic       key_db,
  output logic [3:0] col,
  output logic       key_raw,
  output logic [3:0] key_code,
  output logic [3:0] key_prev,
  output logic       new_key
);

  localparam int CW = $clog2(SCAN_DIVIDER);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIVIDER - 16'd1);

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    HOLD         = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [1:0]    idx_reg, idx_next;
  logic [1:0]    row_idx_reg, row_idx_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] abandon_reg, abandon_next;
  logic          key_raw_reg, key_raw_next;
  logic [3:0]    key_code_reg, key_code_next;
  logic          new_key_reg, new_key_next;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row wins when several are pressed in one column.
  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] sel;
    if (!r[0])      sel = 2'd0;
    else if (!r[1]) sel = 2'd1;
    else if (!r[2]) sel = 2'd2;
    else            sel = 2'd3;
    return sel;
  endfunction

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    row_idx_next  = row_idx_reg;
    cnt_next      = cnt_reg;
    abandon_next  = abandon_reg;
    key_raw_next  = 1'b0;
    key_code_next = key_code_reg;
    new_key_next  = 1'b0;
    case (state_reg)
      SCAN: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (row != 4'hF) begin
            row_idx_next = low_row(row);
            abandon_next = '0;
            state_next   = HOLD;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      HOLD: begin
        key_raw_next = ~row[row_idx_reg];
        if (key_db) begin
          key_code_next = key_map(row_idx_reg, idx_reg);
          new_key_next  = 1'b1;
          state_next    = WAIT_RELEASE;
        end else if (abandon_reg == CNT_LAST) begin
          // Press never confirmed: treat as a bounce and move on to the next column.
          abandon_next = '0;
          cnt_next     = '0;
          idx_next     = idx_reg + 2'd1;
          state_next   = SCAN;
        end else if (!key_raw_reg) begin
          abandon_next = abandon_reg + CW'(1);
        end else begin
          abandon_next = '0;
        end
      end
      WAIT_RELEASE: begin
        key_raw_next = ~row[row_idx_reg];
        if (!key_db) begin
          cnt_next   = '0;
          idx_next   = idx_reg + 2'd1;
          state_next = SCAN;
        end
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= SCAN;
      idx_reg      <= 2'd0;
      row_idx_reg  <= 2'd0;
      cnt_reg      <= '0;
      abandon_reg  <= '0;
      key_raw_reg  <= 1'b0;
      key_code_reg <= 4'h0;
      new_key_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      row_idx_reg  <= row_idx_next;
      cnt_reg      <= cnt_next;
      abandon_reg  <= abandon_next;
      key_raw_reg  <= key_raw_next;
      key_code_reg <= key_code_next;
      new_key_reg  <= new_key_next;
    end
  end

`ifdef KEYPAD_HISTORY_EN
  logic [3:0] key_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev_reg <= 4'h0;
    end else if (state_reg == HOLD && key_db) begin
      key_prev_reg <= key_code_reg;
    end
  end

  assign key_prev = key_prev_reg;
`else
  assign key_prev = 4'h0;
`endif

  assign col      = ~(4'b0001 << idx_reg);
  assign key_raw  = key_raw_reg;
  assign key_code = key_code_reg;
  assign new_key  = new_key_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: physical keypad model, behavioural debouncer and press-level expectations.
// Honours KEYPAD_HISTORY_EN for the key_prev expectation.
module tb_keypad_scanner;

  localparam logic [15:0] DIV  = 16'd4;
  localparam int          DB_N = 10;
  localparam logic [3:0]  KEY_TAB [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                          4'h4, 4'h5, 4'h6, 4'hB,
                                          4'h7, 4'h8, 4'h9, 4'hC,
                                          4'hE, 4'h0, 4'hF, 4'hD};

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic       key_db;
  logic [3:0] col;
  logic       key_raw;
  logic [3:0] key_code;
  logic [3:0] key_prev;
  logic       new_key;

  keypad_scanner #(.SCAN_DIVIDER(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .key_db   (key_db),
    .col      (col),
    .key_raw  (key_raw),
    .key_code (key_code),
    .key_prev (key_prev),
    .new_key  (new_key)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] pressed;
  logic        row_force_en;
  logic [3:0]  row_force;
  int          db_cnt;
  int          pulse_cnt;
  logic        expect_pulse;
  logic        expect_next_col;
  int          exp_col;
  logic [3:0]  exp_code;
  logic [3:0]  exp_prev;
  logic [3:0]  model_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] col_of(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  // Physical keypad: a row reads low when a pressed key on it sits in the driven column.
  function automatic logic [3:0] rows_for(input logic [3:0] cl, input logic [15:0] pr);
    logic [3:0] rr;
    rr = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pr[r*4+c] && !cl[c]) rr[r] = 1'b0;
    return rr;
  endfunction

  // One clock: observe outputs, step the debouncer model, drive new row values.
  task automatic cycle();
    @(negedge clk);
    if (new_key) pulse_cnt++;
    if (expect_pulse) begin
      check("new_key_pulse", new_key, 1);
      check("key_code_at_pulse", key_code, exp_code);
      check("key_prev_at_pulse", key_prev, exp_prev);
      check("col_frozen_at_pulse", col, col_of(exp_col));
      expect_pulse = 1'b0;
    end
    if (expect_next_col) begin
      check("col_after_release", col, col_of((exp_col + 1) % 4));
      expect_next_col = 1'b0;
    end
    if (key_raw == key_db) begin
      db_cnt = 0;
    end else begin
      db_cnt++;
      if (db_cnt >= DB_N) begin
        key_db = key_raw;
        db_cnt = 0;
        if (key_raw) expect_pulse = 1'b1;
        else         expect_next_col = 1'b1;
      end
    end
    row = row_force_en ? row_force : rows_for(col, pressed);
  endtask

  task automatic hit_reset();
    pressed         = '0;
    row_force_en    = 1'b0;
    row             = 4'hF;
    key_db          = 1'b0;
    db_cnt          = 0;
    expect_pulse    = 1'b0;
    expect_next_col = 1'b0;
    model_code      = 4'h0;
    reset           = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string where);
    check({where, "_col"}, col, 4'b1110);
    check({where, "_key_code"}, key_code, 4'h0);
    check({where, "_new_key"}, new_key, 0);
    check({where, "_key_raw"}, key_raw, 0);
    check({where, "_key_prev"}, key_prev, 4'h0);
  endtask

  // Press one key (plus optionally a higher row in the same column), bounce, hold, release.
  task automatic press_key(input int r, input int r2, input int c, input int nb, input int hold);
    logic [15:0] mask;
    int n;
    mask = '0;
    mask[r*4+c] = 1'b1;
    if (r2 >= 0) mask[r2*4+c] = 1'b1;
    exp_col  = c;
    exp_code = KEY_TAB[r*4+c];
`ifdef KEYPAD_HISTORY_EN
    exp_prev = model_code;
`else
    exp_prev = 4'h0;
`endif
    pulse_cnt = 0;
    for (int b = 0; b < nb; b++) begin
      pressed = mask;
      repeat ($urandom_range(1, 6)) cycle();
      pressed = '0;
      repeat ($urandom_range(1, 6)) cycle();
    end
    pressed = mask;
    repeat (hold) cycle();
    check("col_held", col, col_of(c));
    pressed = '0;
    n = 0;
    while (key_db && n < 60) begin
      cycle();
      n++;
    end
    check("release_seen", key_db, 0);
    cycle();
    check("pulse_count", pulse_cnt, 1);
    check("key_code_after", key_code, exp_code);
    check("key_prev_after", key_prev, exp_prev);
    model_code = exp_code;
    $display("[TB] press r%0d c%0d extra %0d bounces %0d -> code %0h prev %0h pulses %0d",
             r, c, r2, nb, key_code, key_prev, pulse_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int n;
    pressed = '0;
    row_force_en = 1'b0;
    row_force = 4'hF;
    row = 4'hF;
    key_db = 1'b0;
    reset = 1'b1;
    pulse_cnt = 0;
    exp_col = 0;
    exp_code = 4'h0;
    exp_prev = 4'h0;
    repeat (2) @(negedge clk);

    // Reset state, then idle scanning: column changes every DIV cycles.
    hit_reset();
    check_reset_state("reset");
    pulse_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      check($sformatf("idle_col_k%0d", k), col, col_of((k / 4) % 4));
      cycle();
    end
    check("idle_no_pulse", pulse_cnt, 0);
    $display("[TB] idle scan 40 cycles, pulses %0d", pulse_cnt);

    // Glitch on r0 at the c0 sample: HOLD, timeout, resume at c1 with no key.
    hit_reset();
    pulse_cnt = 0;
    cycle();
    cycle();
    row_force_en = 1'b1;
    row_force = 4'b1110;
    cycle();
    cycle();
    row_force_en = 1'b0;
    for (int k = 5; k <= 8; k++) cycle();
    check("glitch_col_frozen", col, 4'b1110);
    found = 0;
    n = 0;
    while (col != 4'b1101 && n < 20) begin
      cycle();
      n++;
    end
    check("glitch_col_advance", col, 4'b1101);
    check("glitch_no_pulse", pulse_cnt, 0);
    $display("[TB] glitch r0 c0 -> col %b pulses %0d", col, pulse_cnt);

    // Directed presses.
    hit_reset();
    press_key(1, -1, 2, 3, 80);
    press_key(1, -1, 1, 0, 70);
    press_key(3, -1, 3, 1, 70);
    press_key(0, 3, 1, 0, 70);

    // Randomized presses.
    for (int i = 0; i < 10; i++) begin
      int r, c, r2;
      r  = $urandom_range(0, 3);
      c  = $urandom_range(0, 3);
      r2 = ($urandom_range(0, 1) == 1) ? $urandom_range(r, 3) : -1;
      press_key(r, r2, c, $urandom_range(0, 3), $urandom_range(60, 100));
      repeat ($urandom_range(0, 10)) cycle();
    end

    // Reset while in HOLD, after a prior accept left key_code non-zero.
    press_key(2, -1, 2, 0, 70);
    pressed = 16'h0001 << (1*4 + 3);
    n = 0;
    while (!key_raw && n < 40) begin
      cycle();
      n++;
    end
    check("hold_reached", key_raw, 1);
    hit_reset();
    check_reset_state("reset_hold");
    $display("[TB] reset in HOLD -> col %b code %0h raw %0d", col, key_code, key_raw);

    // Reset while in WAIT_RELEASE with the key still held.
    pulse_cnt = 0;
    exp_col = 0;
    exp_code = KEY_TAB[2*4+0];
`ifdef KEYPAD_HISTORY_EN
    exp_prev = model_code;
`else
    exp_prev = 4'h0;
`endif
    pressed = 16'h0001 << (2*4 + 0);
    n = 0;
    while (pulse_cnt == 0 && n < 80) begin
      cycle();
      n++;
    end
    check("wait_pulse_seen", pulse_cnt, 1);
    repeat (3) cycle();
    hit_reset();
    check_reset_state("reset_wait");
    $display("[TB] reset in WAIT_RELEASE -> col %b code %0h raw %0d", col, key_code, key_raw);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Column-scanning controller for the 4x4 matrix keypad. Drives one active-low column at a time and samples the synchronized active-low rows. On a press it freezes the scan and sends a raw "key down" level to the debouncer. It then emits a one-cycle `new_key` pulse with a 4-bit key code once the debouncer confirms the press. The block sits between the row synchronizer/column pins and the display logic, wrapped around the debouncer (`key_raw` → `s_in`, `s_out` → `key_db`).

## Interface
- `SCAN_DIVIDER`, default 16'd5000: clock cycles each column is driven; also the abandon timeout in HOLD. Must be ≥ 2.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `row` input 4: keypad rows, active-low, already synchronized to `clk`.
- `key_db` input 1: debounced press level from the debouncer `s_out`.
- `col` output 4: column drive, active-low, one-hot-low.
- `key_raw` output 1: registered raw press level for the frozen row/column; goes to debouncer `s_in`.
- `key_code` output 4: code of the most recently accepted key.
- `key_prev` output 4: code accepted before `key_code` (see Configuration).
- `new_key` output 1: one-cycle pulse when `key_code` updates.

## Operation
- States: SCAN, HOLD, WAIT_RELEASE. Reset state is SCAN.
- Column index is 2 bits, so `col = ~(4'b0001 << idx)`.
- Scan counter width is `$clog2(SCAN_DIVIDER)`.
- **SCAN**
  - The scan counter counts 0..SCAN_DIVIDER-1; on wrap, idx increments (3→0).
  - Rows are evaluated only when counter == SCAN_DIVIDER-1 (settled column).
  - If `row != 4'hF` then: latch `row_idx` as the lowest-index low row, hold idx, clear counters, go to HOLD.
  - Otherwise idx advances as normal.
- **HOLD**
  - `col` is frozen and `key_raw <= ~row[row_idx]` every cycle.
  - If `key_db == 1`: `key_code <= map(row_idx, idx)`, `new_key <= 1`, go to WAIT_RELEASE.
  - Else, while `key_raw == 0` the abandon counter increments; any cycle with `key_raw == 1` clears it.
  - When the abandon counter reaches SCAN_DIVIDER-1: go to SCAN. idx advances by one and the scan counter restarts at 0. This case is a bounce with no accept.
  - If `key_db` rises on the same cycle as the timeout, the accept wins.
- **WAIT_RELEASE**
  - `col` stays frozen and `key_raw` keeps tracking the row; `new_key` is 0.
  - When `key_db == 0`: go to SCAN, idx advances, scan counter restarts at 0.
  - Holding a key emits exactly one `new_key`.
- **Key map**, row r / column c:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- Multiple rows low in one column: the lowest row index wins. Keys in other columns are ignored until the scan resumes.

## Timing
- Reset values: state SCAN, idx 0, `col = 4'b1110`, `key_raw = 0`, `key_code = 0`, `key_prev = 0`, `new_key = 0`, all counters 0.
- Reset mid-operation clears everything on the next edge. No `new_key` is emitted for a pending press.
- Press detection happens on the last cycle of a column period; HOLD begins the next cycle.
- `key_raw` lags `row` by 1 cycle.
- `new_key` and the updated `key_code` are asserted on the cycle after `key_db` is sampled high in HOLD.
- `new_key` is high for exactly 1 cycle.
- After `key_db` falls in WAIT_RELEASE, `col` shows the next column 1 cycle later.

## Configuration
- `KEYPAD_HISTORY_EN` defined: on every accept, `key_prev <= key_code` (the old value) in the same cycle that `key_code` updates. This is a two-digit history for the display.
- `KEYPAD_HISTORY_EN` undefined: `key_prev` is tied to 4'h0 and no history register is built.

## Test plan
All scenarios use SCAN_DIVIDER=4 and the real debouncer with DEBOUNCE_DIVIDER=100 in the loop.
- No press, rows=4'hF for 40 cycles → `col` cycles 1110→1101→1011→0111→1110, changing every 4 cycles; `new_key` stays 0.
- Press r1/c2 held 300 cycles, with 3 bounces of 15 cycles at onset → exactly one `new_key` pulse with `key_code = 4'h6`; `col` stays 1011 until release plus 1 cycle.
- Two accepts, "5" then "D", with `KEYPAD_HISTORY_EN` defined → after the second pulse `key_code = 4'hD` and `key_prev = 4'h5`; without the macro, `key_prev = 0`.
- Glitch: a 2-cycle low on r0 at the c0 sample, then released → state returns to SCAN after the timeout, `col` advances to 1101, no `new_key`.
- Rows r0 and r3 both low on c1 → `key_code = 4'h2`.
- Reset asserted in HOLD and in WAIT_RELEASE → next edge gives `col = 4'b1110`, `key_code = 0`, `new_key = 0`, `key_raw = 0`.
